// File: rtl/dac_tx_pkg.sv
// Shared types and defaults for the WM8731 DAC transmit path.
package dac_tx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_W   = 16;
    localparam int DEFAULT_BCLK_DIV = 4;

    function automatic int frame_bits(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/dac_tx_if.sv
// Sample-pair valid/ready port feeding the DAC transmitter.
interface dac_tx_if
    import dac_tx_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);

    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_left;
    logic signed [DATA_W-1:0] s_right;

    modport master (output s_valid, output s_left, output s_right, input  s_ready);
    modport slave  (input  s_valid, input  s_left, input  s_right, output s_ready);

endinterface

// File: rtl/dac_tx_bclk_gen.sv
// Bit-clock divider: toggles b_clk every BCLK_DIV cycles while running and
// flags the cycle on which b_clk is about to rise or fall.
module bclk_gen #(
    parameter int BCLK_DIV = 4
) (
    input  logic m_clk,
    input  logic rst,
    input  logic run,
    output logic b_clk,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam logic [CNT_W-1:0] TC    = CNT_W'(BCLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             tc;

    // Strobes are combinational so that registers in the parent update on the
    // very edge that moves b_clk.
    assign tc   = run && (cnt == TC);
    assign rise = tc && !b_clk;
    assign fall = tc && b_clk;

    always_ff @(posedge m_clk) begin
        if (rst || !run) begin
            cnt   <= '0;
            b_clk <= 1'b0;
        end else if (tc) begin
            cnt   <= '0;
            b_clk <= ~b_clk;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dac_tx.sv
// WM8731 DAC transmitter: clock master sending left then right sample,
// MSB first, as one 2*DATA_W bit frame per dac_lr_clk period.
module dac_tx
    import dac_tx_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int BCLK_DIV = DEFAULT_BCLK_DIV
) (
    input  logic    m_clk,
    input  logic    rst,
    input  logic    en,
    dac_tx_if.slave smp,
    output logic    b_clk,
    output logic    dac_lr_clk,
    output logic    dacdat,
    output logic    busy,
    output logic    underflow
);

    localparam int               FB      = frame_bits(DATA_W);
    localparam int               BC_W    = $clog2(FB);
    localparam logic [BC_W-1:0]  LAST    = BC_W'(FB - 1);
    localparam logic [BC_W-1:0]  HALF_M1 = BC_W'(DATA_W - 1);

    state_t                   state;
    logic [BC_W-1:0]          bit_cnt;
    logic                     full;
    logic signed [DATA_W-1:0] hold_left;
    logic signed [DATA_W-1:0] hold_right;
    logic [FB-1:0]            shift;
    logic [FB-1:0]            next_word;
    logic                     rise;
    logic                     fall;
    logic                     frame_start;
    logic                     accept;
    logic                     load;

    bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
        .m_clk (m_clk),
        .rst   (rst),
        .run   (busy),
        .b_clk (b_clk),
        .rise  (rise),
        .fall  (fall)
    );

    assign busy        = (state == RUN);
    assign smp.s_ready = !full;
    assign accept      = smp.s_valid && !full;
    assign frame_start = rise && (bit_cnt == LAST);
    assign load        = frame_start && full;

    // An empty holding register at frame start sends a silent frame; a pair
    // accepted in that same cycle waits for the following frame.
    always_comb begin
        next_word = shift;
        if (frame_start) begin
            next_word = load ? {hold_left, hold_right} : '0;
        end
    end

    always_ff @(posedge m_clk) begin
        if (accept) begin
            hold_left  <= smp.s_left;
            hold_right <= smp.s_right;
        end
        if (rise) begin
            shift <= next_word << 1;
        end
    end

    always_ff @(posedge m_clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= LAST;
            full       <= 1'b0;
            dac_lr_clk <= 1'b0;
            dacdat     <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            underflow <= 1'b0;
            if (accept) begin
                full <= 1'b1;
            end else if (load) begin
                full <= 1'b0;
            end

            case (state)
                IDLE: begin
                    bit_cnt    <= LAST;
                    dac_lr_clk <= 1'b0;
                    dacdat     <= 1'b0;
                    if (en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (rise) begin
                        dacdat <= next_word[FB-1];
                        if (frame_start) begin
                            bit_cnt    <= '0;
                            dac_lr_clk <= 1'b1;
                            underflow  <= !full;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == HALF_M1) begin
                                dac_lr_clk <= 1'b0;
                            end
                        end
                    end
                    // Stopping is only considered once the last bit has been sampled.
                    if (fall && (bit_cnt == LAST) && !en) begin
                        state  <= IDLE;
                        dacdat <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_tx.sv
// Bench for dac_tx: table-driven frame vectors, hand-written corner cases and
// a randomized cycle-accurate comparison against a timing-rule reference model.
module tb_dac_tx;

    localparam int DATA_W    = 16;
    localparam int BCLK_DIV  = 4;
    localparam int FRAME_CYC = 4 * DATA_W * BCLK_DIV;

    logic m_clk = 1'b0;
    logic rst   = 1'b1;
    logic en    = 1'b0;
    logic b_clk, dac_lr_clk, dacdat, busy, underflow;

    dac_tx_if #(.DATA_W(DATA_W)) sif ();

    dac_tx #(.DATA_W(DATA_W), .BCLK_DIV(BCLK_DIV)) dut (
        .m_clk      (m_clk),
        .rst        (rst),
        .en         (en),
        .smp        (sif.slave),
        .b_clk      (b_clk),
        .dac_lr_clk (dac_lr_clk),
        .dacdat     (dacdat),
        .busy       (busy),
        .underflow  (underflow)
    );

    always #5 m_clk = ~m_clk;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;

    always @(posedge m_clk) cyc++;

    typedef struct {
        logic [31:0] word;
        logic        uf;
        int          hi;
        longint      t;
    } frame_t;

    frame_t frames[$];

    // Codec-side receiver: samples dacdat on every b_clk falling edge after lr rises.
    logic        prev_lr = 1'b0, prev_bclk = 1'b0, mon_active = 1'b0, mon_uf = 1'b0;
    logic [31:0] mon_word = '0;
    int          mon_bits = 0, mon_hi = 0;
    longint      mon_t = 0;

    always @(negedge m_clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else begin
            if (dac_lr_clk && !prev_lr) begin
                mon_active = 1'b1;
                mon_bits   = 0;
                mon_hi     = 0;
                mon_word   = '0;
                mon_uf     = underflow;
                mon_t      = cyc;
            end
            if (mon_active && prev_bclk && !b_clk) begin
                mon_word = {mon_word[30:0], dacdat};
                if (dac_lr_clk) mon_hi++;
                mon_bits++;
                if (mon_bits == 32) begin
                    frames.push_back('{word: mon_word, uf: mon_uf, hi: mon_hi, t: mon_t});
                    mon_active = 1'b0;
                end
            end
        end
        prev_lr   = dac_lr_clk;
        prev_bclk = b_clk;
    end

    task automatic step();
        @(posedge m_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        en          = 1'b0;
        sif.s_valid = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        frames.delete();
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r, input string name);
        sif.s_left  = l;
        sif.s_right = r;
        sif.s_valid = 1'b1;
        check(name, {31'b0, sif.s_ready}, 32'd1);
        step();
        sif.s_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int i;
        i = 0;
        while (frames.size() < n && i < budget) begin
            step();
            i++;
        end
        check(name, {31'b0, frames.size() >= n}, 32'd1);
    endtask

    task automatic wait_lr(input string name);
        int i;
        i = 0;
        while (!dac_lr_clk && i < 50) begin
            step();
            i++;
        end
        check(name, {31'b0, dac_lr_clk}, 32'd1);
    endtask

    typedef struct {
        logic [15:0] left;
        logic [15:0] right;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[4];

    // Reference model state for the randomized run.
    logic [31:0] words[$];
    bit          ufs[$];
    logic        m_full;
    logic [15:0] m_l, m_r;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sif.s_valid = 1'b0;
        sif.s_left  = '0;
        sif.s_right = '0;

        vecs[0] = '{left: 16'hA5A5, right: 16'h3C3C, word: 32'hA5A53C3C};
        vecs[1] = '{left: 16'h1234, right: 16'h5678, word: 32'h12345678};
        vecs[2] = '{left: 16'hFFFF, right: 16'h0000, word: 32'hFFFF0000};
        vecs[3] = '{left: 16'h8000, right: 16'h0001, word: 32'h80000001};

        // Reset values, observed while reset is still held.
        rst = 1'b1;
        repeat (3) step();
        check("rst_bclk", {31'b0, b_clk}, 32'd0);
        check("rst_lr", {31'b0, dac_lr_clk}, 32'd0);
        check("rst_dacdat", {31'b0, dacdat}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_underflow", {31'b0, underflow}, 32'd0);
        check("rst_ready", {31'b0, sif.s_ready}, 32'd1);

        // Table vectors: one pair in, one full frame out.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            push(vecs[v].left, vecs[v].right, "vec_push_ready");
            check("vec_ready_full", {31'b0, sif.s_ready}, 32'd0);
            en = 1'b1;
            step();
            check("vec_busy_next_cycle", {31'b0, busy}, 32'd1);
            wait_frames(1, 600, "vec_frame_wait");
            if (frames.size() > 0) begin
                check("vec_word", frames[0].word, vecs[v].word);
                check("vec_underflow", {31'b0, frames[0].uf}, 32'd0);
                check("vec_lr_high_bits", frames[0].hi, 32'd16);
            end
        end

        // Idle stream: silent frames with one underflow pulse per frame.
        do_reset();
        en = 1'b1;
        wait_frames(2, 700, "uf_frame_wait");
        if (frames.size() >= 2) begin
            check("uf_word0", frames[0].word, 32'h0);
            check("uf_flag0", {31'b0, frames[0].uf}, 32'd1);
            check("uf_word1", frames[1].word, 32'h0);
            check("uf_flag1", {31'b0, frames[1].uf}, 32'd1);
            check("uf_spacing", 32'(frames[1].t - frames[0].t), FRAME_CYC);
        end

        // Back-to-back pairs: second waits until the first is loaded.
        do_reset();
        push(16'hCAFE, 16'hBEEF, "b2b_push_a");
        sif.s_left  = 16'h0F0F;
        sif.s_right = 16'hF0F0;
        sif.s_valid = 1'b1;
        step();
        check("b2b_blocked", {31'b0, sif.s_ready}, 32'd0);
        en = 1'b1;
        begin
            int i;
            i = 0;
            while (!sif.s_ready && i < 100) begin
                step();
                i++;
            end
        end
        check("b2b_ready_at_frame_start", {31'b0, dac_lr_clk}, 32'd1);
        step();
        sif.s_valid = 1'b0;
        check("b2b_full_again", {31'b0, sif.s_ready}, 32'd0);
        wait_frames(2, 700, "b2b_frame_wait");
        if (frames.size() >= 2) begin
            check("b2b_word_a", frames[0].word, 32'hCAFEBEEF);
            check("b2b_word_b", frames[1].word, 32'h0F0FF0F0);
            check("b2b_uf_b", {31'b0, frames[1].uf}, 32'd0);
        end

        // Dropping en mid-frame still completes the frame, then idles.
        do_reset();
        push(16'h1234, 16'h5678, "drop_push");
        en = 1'b1;
        wait_lr("drop_frame_start");
        begin
            int   i, rises;
            logic pb;
            i = 0; rises = 0; pb = b_clk;
            while (rises < 5 && i < 100) begin
                step();
                i++;
                if (b_clk && !pb) rises++;
                pb = b_clk;
            end
        end
        en = 1'b0;
        wait_frames(1, 400, "drop_frame_wait");
        if (frames.size() > 0) begin
            check("drop_word", frames[0].word, 32'h12345678);
            check("drop_uf", {31'b0, frames[0].uf}, 32'd0);
        end
        repeat (2) step();
        check("drop_busy", {31'b0, busy}, 32'd0);
        repeat (20) step();
        check("drop_idle_bclk", {31'b0, b_clk}, 32'd0);
        check("drop_idle_lr", {31'b0, dac_lr_clk}, 32'd0);
        check("drop_idle_dacdat", {31'b0, dacdat}, 32'd0);
        check("drop_no_more_frames", frames.size(), 32'd1);

        // Reset mid-frame with a pair held.
        do_reset();
        push(16'h1111, 16'h2222, "mrst_push_a");
        en = 1'b1;
        wait_lr("mrst_frame_start");
        push(16'h3333, 16'h4444, "mrst_push_b");
        repeat (40) step();
        check("mrst_busy_before", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        step();
        check("mrst_bclk", {31'b0, b_clk}, 32'd0);
        check("mrst_lr", {31'b0, dac_lr_clk}, 32'd0);
        check("mrst_dacdat", {31'b0, dacdat}, 32'd0);
        check("mrst_busy", {31'b0, busy}, 32'd0);
        check("mrst_underflow", {31'b0, underflow}, 32'd0);
        check("mrst_ready", {31'b0, sif.s_ready}, 32'd1);
        rst = 1'b0;
        en  = 1'b0;

        // Randomized run against the timing-rule model. Edge n=0 samples en=1.
        do_reset();
        en     = 1'b1;
        m_full = 1'b0;
        m_l    = '0;
        m_r    = '0;
        words.delete();
        ufs.delete();
        for (int n = 0; n < 6 * FRAME_CYC; n++) begin
            bit          fs, pre;
            logic        vld;
            logic [15:0] l, r;
            int          j, k, b;
            logic        e_bclk, e_lr, e_dat, e_uf;
            fs  = (n >= BCLK_DIV) && (((n - BCLK_DIV) % FRAME_CYC) == 0);
            vld = ($urandom_range(0, 149) == 0);
            // Keep frame 1 free of new pairs so frame 2 starts empty while a pair arrives.
            if (n >= FRAME_CYC + BCLK_DIV && n < 2 * FRAME_CYC + BCLK_DIV) vld = 1'b0;
            if (n == 2 * FRAME_CYC + BCLK_DIV) vld = 1'b1;
            l = 16'($urandom());
            r = 16'($urandom());
            sif.s_valid = vld;
            sif.s_left  = l;
            sif.s_right = r;
            @(posedge m_clk);
            pre = m_full;
            if (fs) begin
                words.push_back(pre ? {m_l, m_r} : 32'h0);
                ufs.push_back(!pre);
            end
            if (vld && !pre) begin
                m_full = 1'b1;
                m_l    = l;
                m_r    = r;
            end else if (fs && pre) begin
                m_full = 1'b0;
            end
            #1;
            if (n >= BCLK_DIV) begin
                j      = (n - BCLK_DIV) / (2 * BCLK_DIV);
                k      = j / 32;
                b      = j % 32;
                e_bclk = ((n / BCLK_DIV) % 2) == 1;
                e_lr   = (b < 16);
                e_dat  = words[k][31 - b];
                e_uf   = fs && ufs[k];
            end else begin
                e_bclk = 1'b0;
                e_lr   = 1'b0;
                e_dat  = 1'b0;
                e_uf   = 1'b0;
            end
            check("model_busy", {31'b0, busy}, 32'd1);
            check("model_bclk", {31'b0, b_clk}, {31'b0, e_bclk});
            check("model_lr", {31'b0, dac_lr_clk}, {31'b0, e_lr});
            check("model_dacdat", {31'b0, dacdat}, {31'b0, e_dat});
            check("model_underflow", {31'b0, underflow}, {31'b0, e_uf});
            check("model_ready", {31'b0, sif.s_ready}, {31'b0, !m_full});
        end
        sif.s_valid = 1'b0;
        en          = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
